// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART RX sampling path.
//   MAX_SAMPLES_DEF : default largest odd sample count
//   UART_IDLE       : idle (mark) level of the serial line
//   clamp_samples() : maps a requested sample count onto a legal odd count
//   fit_half()      : half-width of the majority window that fits a bit period
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int   MAX_SAMPLES_DEF = 7;
  localparam logic UART_IDLE       = 1'b1;

  // 0 -> 1, above max -> max, even -> one less (max is always odd).
  function automatic int unsigned clamp_samples(input int unsigned req,
                                                input int unsigned max_n);
    int unsigned n;
    n = req;
    if (n == 0)          n = 1;
    else if (n > max_n)  n = max_n;
    else if (n[0] == 1'b0) n = n - 1;
    return n;
  endfunction

  // Half-width h so that [mid-h, mid+h] plus the decide edge mid+h+1 stay
  // inside 0..prescale-1. Saturates at 0 for tiny prescale values.
  function automatic int unsigned fit_half(input int unsigned prescale,
                                           input int unsigned n_req);
    int unsigned mid;
    int unsigned h;
    int unsigned lim;
    mid = prescale >> 1;
    h   = (n_req - 1) >> 1;
    lim = (prescale >= mid + 2) ? prescale - mid - 2 : 0;
    if (mid < h) h = mid;
    if (lim < h) h = lim;
    return h;
  endfunction

endpackage

// File: rtl/data_sampler_mv_if.sv
// ---------------------------------------------------------------------------
// data_sampler_mv_if
// Signal bundle between the RX FSM / edge counter and the majority sampler.
//   rx_in, prescale, edge_cnt, num_samples, dat_samp_en : to the sampler
//   sampled_data, sample_valid, noise_err               : from the sampler
// master: the side driving the RX line and counters; slave: the sampler.
// ---------------------------------------------------------------------------
interface data_sampler_mv_if #(
  parameter int PRESCALE_W = 6,
  parameter int NS_W       = 3
) ();

  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [NS_W-1:0]       num_samples;
  logic                  dat_samp_en;
  logic                  sampled_data;
  logic                  sample_valid;
  logic                  noise_err;

  modport master (
    output rx_in, prescale, edge_cnt, num_samples, dat_samp_en,
    input  sampled_data, sample_valid, noise_err
  );

  modport slave (
    input  rx_in, prescale, edge_cnt, num_samples, dat_samp_en,
    output sampled_data, sample_valid, noise_err
  );

endinterface

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (2 clk latency)
// ---------------------------------------------------------------------------
module bit_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so both stages shift on the same edge.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/data_sampler_mv.sv
// ---------------------------------------------------------------------------
// data_sampler_mv
// N-sample majority-vote bit sampler for the UART RX path. The sample count
// (1/3/5/7.. up to MAX_SAMPLES) is clamped and then fitted around the middle
// of the bit period; the registered decision comes with a one-cycle valid
// strobe and a noise flag for non-unanimous samples.
//   clk : oversampling clock
//   rst : asynchronous active-low reset
//   bus : data_sampler_mv_if.slave (rx_in, prescale, edge_cnt, num_samples,
//         dat_samp_en in; sampled_data, sample_valid, noise_err out)
// Build option: SAMPLER_INPUT_SYNC_EN inserts a 2-flop synchronizer (idle
// reset value) on rx_in; otherwise rx_in is used as-is.
// ---------------------------------------------------------------------------
module data_sampler_mv
  import uart_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int MAX_SAMPLES = MAX_SAMPLES_DEF,
  parameter int NS_W        = 3
) (
  input logic              clk,
  input logic              rst,
  data_sampler_mv_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_SAMPLES + 1);
  // One extra bit so mid+h+1 never wraps.
  localparam int EW    = PRESCALE_W + 1;

  logic rx_s;

`ifdef SAMPLER_INPUT_SYNC_EN
  bit_sync #(.RESET_VAL(UART_IDLE)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (bus.rx_in),
    .q     (rx_s)
  );
`else
  assign rx_s = bus.rx_in;
`endif

  logic                  en_d;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic [NS_W-1:0]       cfg_ns;
  logic [CNT_W-1:0]      ones;
  logic [CNT_W-1:0]      taken;
  logic                  data_q;
  logic                  valid_q;
  logic                  noise_q;

  logic                  en_rise;
  logic [PRESCALE_W-1:0] eff_prescale;
  logic [NS_W-1:0]       eff_ns;
  int unsigned           n_req_i;
  int unsigned           h_i;
  logic [EW-1:0]         half;
  logic [EW-1:0]         mid;
  logic [EW-1:0]         win_start;
  logic [EW-1:0]         win_stop;
  logic [EW-1:0]         decide;
  logic [EW-1:0]         expected;
  logic [EW-1:0]         edge_x;
  logic [CNT_W-1:0]      n_eff;
  logic                  take;
  logic                  at_decide;

  assign en_rise = bus.dat_samp_en & ~en_d;

  always_comb begin
    // NOTE: defaults first, so every path assigns and no latch is inferred.
    eff_prescale = cfg_prescale;
    eff_ns       = cfg_ns;
    // On the enable's first cycle the latch has not happened yet, so the
    // window is computed from the live inputs being captured this edge.
    if (en_rise) begin
      eff_prescale = bus.prescale;
      eff_ns       = bus.num_samples;
    end
    n_req_i   = clamp_samples(32'(eff_ns), 32'(MAX_SAMPLES));
    h_i       = fit_half(32'(eff_prescale), n_req_i);
    half      = EW'(h_i);
    mid       = EW'(eff_prescale) >> 1;
    win_start = mid - half;
    win_stop  = mid + half;
    decide    = win_stop + EW'(1);
    n_eff     = CNT_W'(2 * h_i + 1);
    edge_x    = EW'(bus.edge_cnt);
    // Only the next expected edge counts, so a held edge_cnt is taken once.
    expected  = win_start + EW'(taken);
    take      = (edge_x >= win_start) && (edge_x <= win_stop) &&
                (edge_x == expected);
    at_decide = (edge_x == decide);
  end

  // Configuration capture on the rising edge of the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d         <= 1'b0;
      cfg_prescale <= '0;
      cfg_ns       <= '0;
    end else begin
      en_d <= bus.dat_samp_en;
      if (en_rise) begin
        cfg_prescale <= bus.prescale;
        cfg_ns       <= bus.num_samples;
      end
    end
  end

  // Sample accumulation and the registered decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones    <= '0;
      taken   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      noise_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.dat_samp_en) begin
        ones  <= '0;
        taken <= '0;
      end else if (take) begin
        ones  <= ones + CNT_W'(rx_s);
        taken <= taken + CNT_W'(1);
      end else if (at_decide) begin
        // A skipped edge leaves taken short: drop the bit without a strobe.
        if (taken == n_eff) begin
          data_q  <= EW'(ones) > half;
          noise_q <= (ones != '0) && (ones != n_eff);
          valid_q <= 1'b1;
        end
        ones  <= '0;
        taken <= '0;
      end else if (edge_x == '0) begin
        ones  <= '0;
        taken <= '0;
      end
    end
  end

  assign bus.sampled_data = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.noise_err    = noise_q;

endmodule

// File: tb/tb_data_sampler_mv.sv
// ---------------------------------------------------------------------------
// tb_data_sampler_mv
// Directed bench for data_sampler_mv. Each bit is driven as a sweep of
// edge_cnt 0..prescale-1 with rx_in taken from a per-edge pattern; the
// number of valid strobes and the held outputs are compared against
// hand-computed values. Build option SAMPLER_INPUT_SYNC_EN shifts the
// stimulus by the synchronizer lag and adds the glitch scenario.
// ---------------------------------------------------------------------------
module tb_data_sampler_mv;

`ifdef SAMPLER_INPUT_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif
  localparam int NONE = 99;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  data_sampler_mv_if #(.PRESCALE_W(6), .NS_W(3)) bus ();

  data_sampler_mv #(.PRESCALE_W(6), .MAX_SAMPLES(7), .NS_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One bit period. drop_at: first edge with enable low; skip_at: edge never
  // presented; hold_at: edge presented twice, second time with rx inverted.
  task automatic run_bit(input int p, input int ns, input logic [15:0] pat,
                         input int lag, input int drop_at, input int skip_at,
                         input int hold_at, output int pulses);
    int idx;
    pulses = 0;
    bus.dat_samp_en = 1'b0;
    bus.edge_cnt    = '0;
    bus.prescale    = 6'(p);
    bus.num_samples = 3'(ns);
    @(posedge clk); #1;
    if (bus.sample_valid) pulses++;
    for (int e = 0; e < p; e++) begin
      if (e == skip_at) continue;
      for (int r = 0; r < ((e == hold_at) ? 2 : 1); r++) begin
        bus.edge_cnt    = 6'(e);
        bus.dat_samp_en = (e < drop_at);
        idx             = e + lag;
        bus.rx_in       = (idx < 16) ? pat[idx] : 1'b0;
        if (r == 1) bus.rx_in = ~bus.rx_in;
        @(posedge clk); #1;
        if (bus.sample_valid) pulses++;
      end
    end
    bus.dat_samp_en = 1'b0;
    bus.edge_cnt    = '0;
    @(posedge clk); #1;
    if (bus.sample_valid) pulses++;
  endtask

  task automatic check_bit(input string tag, input int pulses,
                           input int exp_pulses, input logic exp_data,
                           input logic exp_noise);
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check({tag, "_data"}, 32'(bus.sampled_data), 32'(exp_data));
    check({tag, "_noise"}, 32'(bus.noise_err), 32'(exp_noise));
  endtask

  initial begin
    int pulses;
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    bus.rx_in       = 1'b0;
    bus.prescale    = '0;
    bus.edge_cnt    = '0;
    bus.num_samples = '0;
    bus.dat_samp_en = 1'b0;
    #1;
    check("rst_data", 32'(bus.sampled_data), 32'd0);
    check("rst_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_noise", 32'(bus.noise_err), 32'd0);
`ifdef SAMPLER_INPUT_SYNC_EN
    check("rst_sync_idle", 32'(dut.rx_s), 32'd1);
`endif
    @(posedge clk); #1;
    rst = 1'b1;

    // n=3 window 3..5: 1,0,1 -> majority 1, noisy.
    run_bit(8, 3, 16'h0028, LAG, NONE, NONE, NONE, pulses);
    check_bit("p8n3", pulses, 1, 1'b1, 1'b1);
    // n=5 window 6..10, quiet zero line.
    run_bit(16, 5, 16'h0000, LAG, NONE, NONE, NONE, pulses);
    check_bit("p16n5_zero", pulses, 1, 1'b0, 1'b0);
    // Ones on 6,7,8 only.
    run_bit(16, 5, 16'h01C0, LAG, NONE, NONE, NONE, pulses);
    check_bit("p16n5_three", pulses, 1, 1'b1, 1'b1);
    // 7 requested, fitted to n=5 (edges 2..6): ones at 2,6 -> 0, noisy.
    run_bit(8, 7, 16'h0044, LAG, NONE, NONE, NONE, pulses);
    check_bit("p8n7_fit", pulses, 1, 1'b0, 1'b1);
    // 4 requested -> n=3 (edges 3..5): only edge 4 high -> 0, noisy.
    run_bit(8, 4, 16'h0054, LAG, NONE, NONE, NONE, pulses);
    check_bit("p8n4_even", pulses, 1, 1'b0, 1'b1);
    // 0 requested -> n=1 at edge 4.
    run_bit(8, 0, 16'h0010, LAG, NONE, NONE, NONE, pulses);
    check_bit("p8n0_single", pulses, 1, 1'b1, 1'b0);
`ifndef SAMPLER_INPUT_SYNC_EN
    // Edge 8 held two cycles with rx flipped; the repeat must not count.
    run_bit(16, 5, 16'h00C0, LAG, NONE, NONE, 8, pulses);
    check_bit("held_edge", pulses, 1, 1'b0, 1'b1);
`endif
    // Enable dropped at edge 8: no strobe, outputs hold.
    run_bit(16, 5, 16'h0000, LAG, 8, NONE, NONE, pulses);
`ifndef SAMPLER_INPUT_SYNC_EN
    check_bit("drop_en", pulses, 0, 1'b0, 1'b1);
`else
    check_bit("drop_en", pulses, 0, 1'b1, 1'b0);
`endif
    // Next bit after the abort decodes normally.
    run_bit(16, 5, 16'h07C0, LAG, NONE, NONE, NONE, pulses);
    check_bit("after_drop", pulses, 1, 1'b1, 1'b0);
    // Edge 7 skipped: incomplete window, outputs hold.
    run_bit(16, 5, 16'h0000, LAG, NONE, 7, NONE, pulses);
    check_bit("skip_edge", pulses, 0, 1'b1, 1'b0);

    // Reset asserted mid-window at edge 9.
    bus.prescale    = 6'd16;
    bus.num_samples = 3'd5;
    bus.dat_samp_en = 1'b0;
    @(posedge clk); #1;
    for (int e = 0; e <= 9; e++) begin
      bus.edge_cnt    = 6'(e);
      bus.dat_samp_en = 1'b1;
      bus.rx_in       = 1'b1;
      if (e < 9) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_data", 32'(bus.sampled_data), 32'd0);
    check("midrst_valid", 32'(bus.sample_valid), 32'd0);
    check("midrst_noise", 32'(bus.noise_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    // First full window after reset: ones at 8,10 -> 0, noisy.
    run_bit(16, 5, 16'h0500, LAG, NONE, NONE, NONE, pulses);
    check_bit("post_rst", pulses, 1, 1'b0, 1'b1);

`ifdef SAMPLER_INPUT_SYNC_EN
    run_bit(16, 5, 16'hFFFF, LAG, NONE, NONE, NONE, pulses);
    check_bit("sync_ones", pulses, 1, 1'b1, 1'b0);
    // One-cycle raw glitch at edge 8 lands inside the window via the lag.
    run_bit(16, 5, 16'h0100, 0, NONE, NONE, NONE, pulses);
    check_bit("sync_glitch", pulses, 1, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
